bsg_chip_link_bringup_seq: RTL and testbench

- Per-link bring-up sequencer for one bsg_link endpoint pair: upstream link, downstream link, and core-side FIFO.
- Replaces manual bsg_tag poking of link resets during chip bring-up.
- Drives the token-reset, upstream, downstream and core-reset controls in the mandated order with programmable hold/settle intervals.
- One instance per io or mem link; outputs go to the link's reset synchronizers.

---
 rtl/bsg_chip_link_bringup_seq.sv | 148 ++++++++++++++
 tb/tb_bsg_chip_link_bringup_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_link_bringup_seq.sv
// Per-link bring-up sequencer: orders token/upstream/downstream/core reset release.
// Optional live-check watchdog with retries: BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN.
module bsg_chip_link_bringup_seq #(
  parameter int reset_cycles_p   = 16,
  parameter int tkn_cycles_p     = 4,
  parameter int settle_cycles_p  = 8,
  parameter int timeout_cycles_p = 1024,
  parameter int max_retries_p    = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               start_i,
  input  logic                               abort_i,
  input  logic                               link_live_i,
  output logic                               async_token_reset_o,
  output logic                               up_link_reset_o,
  output logic                               down_link_reset_o,
  output logic                               core_reset_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic [$clog2(max_retries_p+1)-1:0] retry_cnt_o
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
  localparam int max_cycles_lp = max2(max2(reset_cycles_p, tkn_cycles_p),
                                      max2(settle_cycles_p, timeout_cycles_p));
`else
  localparam int max_cycles_lp = max2(max2(reset_cycles_p, tkn_cycles_p), settle_cycles_p);
`endif
  localparam int cnt_width_lp   = $clog2(max_cycles_lp + 1);
  localparam int retry_width_lp = $clog2(max_retries_p + 1);

  typedef logic [cnt_width_lp-1:0]   cnt_t;
  typedef logic [retry_width_lp-1:0] retry_t;

  localparam cnt_t reset_load_lp  = cnt_t'(reset_cycles_p - 1);
  localparam cnt_t tkn_load_lp    = cnt_t'(tkn_cycles_p - 1);
  localparam cnt_t settle_load_lp = cnt_t'(settle_cycles_p - 1);

  typedef enum logic [3:0] {
    IDLE, ASSERT, TKN, TKN_SETTLE, UP, DOWN, CORE, WAIT_LIVE, DONE, ERROR
  } state_e;

  state_e state_r, state_n;
  cnt_t   cnt_r, cnt_n;
  retry_t retry_n;

`ifndef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
  logic unused_live;
  assign unused_live = link_live_i | (timeout_cycles_p == 0);
`endif

  always_comb begin
    state_n = state_r;
    cnt_n   = (cnt_r == '0) ? '0 : cnt_r - 1'b1;
    retry_n = retry_cnt_o;
    if (abort_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (state_r)
        IDLE, DONE, ERROR: if (start_i) begin
          state_n = ASSERT;
          cnt_n   = reset_load_lp;
          retry_n = '0;
        end
        ASSERT: if (cnt_r == '0) begin
          state_n = TKN;
          cnt_n   = tkn_load_lp;
        end
        TKN: if (cnt_r == '0) begin
          state_n = TKN_SETTLE;
          cnt_n   = settle_load_lp;
        end
        TKN_SETTLE: if (cnt_r == '0) begin
          state_n = UP;
          cnt_n   = settle_load_lp;
        end
        UP: if (cnt_r == '0) begin
          state_n = DOWN;
          cnt_n   = settle_load_lp;
        end
        DOWN: if (cnt_r == '0) begin
          state_n = CORE;
          cnt_n   = '0;
        end
`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
        CORE: begin
          state_n = WAIT_LIVE;
          cnt_n   = cnt_t'(timeout_cycles_p - 1);
        end
        // live on the expiry cycle wins over the retry/error decision
        WAIT_LIVE: begin
          if (link_live_i) begin
            state_n = DONE;
          end else if (cnt_r == '0) begin
            if (retry_cnt_o < retry_t'(max_retries_p)) begin
              state_n = ASSERT;
              cnt_n   = reset_load_lp;
              retry_n = retry_cnt_o + 1'b1;
            end else begin
              state_n = ERROR;
            end
          end
        end
`else
        CORE: state_n = DONE;
        WAIT_LIVE: state_n = IDLE;
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r             <= IDLE;
      cnt_r               <= '0;
      retry_cnt_o         <= '0;
      async_token_reset_o <= 1'b0;
      up_link_reset_o     <= 1'b1;
      down_link_reset_o   <= 1'b1;
      core_reset_o        <= 1'b1;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      error_o             <= 1'b0;
    end else begin
      state_r             <= state_n;
      cnt_r               <= cnt_n;
      retry_cnt_o         <= retry_n;
      async_token_reset_o <= (state_n == TKN);
      up_link_reset_o     <= state_n inside {IDLE, ASSERT, TKN, TKN_SETTLE, ERROR};
      down_link_reset_o   <= state_n inside {IDLE, ASSERT, TKN, TKN_SETTLE, UP, ERROR};
      core_reset_o        <= !(state_n inside {CORE, WAIT_LIVE, DONE});
      busy_o              <= !(state_n inside {IDLE, DONE, ERROR});
      done_o              <= (state_n == DONE);
      error_o             <= (state_n == ERROR);
    end
  end

endmodule

// File: tb/tb_bsg_chip_link_bringup_seq.sv
// Directed bench for bsg_chip_link_bringup_seq; expected output vectors are queued per cycle.
module tb_bsg_chip_link_bringup_seq;

  logic       clk = 1'b0;
  logic       reset_i, start_i, abort_i, link_live_i;
  logic       async_token_reset_o, up_link_reset_o, down_link_reset_o, core_reset_o;
  logic       busy_o, done_o, error_o;
  logic [1:0] retry_cnt_o;

  always #5 clk = ~clk;

`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
  localparam int unsigned done_k = 47;
  bsg_chip_link_bringup_seq #(.timeout_cycles_p(8), .max_retries_p(2)) dut (
`else
  localparam int unsigned done_k = 46;
  bsg_chip_link_bringup_seq dut (
`endif
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .link_live_i(link_live_i), .async_token_reset_o(async_token_reset_o),
    .up_link_reset_o(up_link_reset_o), .down_link_reset_o(down_link_reset_o),
    .core_reset_o(core_reset_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .retry_cnt_o(retry_cnt_o)
  );

  // {token, up, down, core, busy, done, error, retry[1:0]}
  localparam logic [8:0] idle_v = 9'b0_111_0_0_0_00;
  localparam logic [8:0] done_v = 9'b0_000_0_1_0_00;
  localparam logic [8:0] err_v  = 9'b0_111_0_0_1_10;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  vec;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned base;

  function automatic logic [8:0] nominal(int unsigned k);
    logic tkn, up, down, core;
    if (k >= done_k) return done_v;
    tkn  = (k >= 17 && k <= 20);
    up   = (k < 29);
    down = (k < 37);
    core = (k < 45);
    return {tkn, up, down, core, 1'b1, 1'b0, 1'b0, 2'b00};
  endfunction

  task automatic push(input int unsigned c, input logic [8:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_run(input int unsigned b, input int unsigned k0, input int unsigned k1,
                          input string tag);
    for (int unsigned k = k0; k <= k1; k++) push(b + k, nominal(k), tag);
  endtask

  task automatic check_cycle();
    exp_t       e;
    logic [8:0] obs;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      obs = {async_token_reset_o, up_link_reset_o, down_link_reset_o, core_reset_o,
             busy_o, done_o, error_o, retry_cnt_o};
      checks++;
      assert (obs === e.vec) else begin
        errors++;
        $error("FAIL %s cycle %0d: observed %b expected %b", e.tag, cyc, obs, e.vec);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
  // attempt j starts at k = 1 + 53*j; 53 = 16+4+8+8+8+1 (CORE) + 8 (WAIT_LIVE)
  function automatic logic [8:0] retry_vec(int unsigned k);
    int unsigned j, m;
    logic [1:0]  r;
    j = (k - 1) / 53;
    m = (k - 1) % 53;
    if (j >= 3) return err_v;
    r = 2'(j);
    if (m < 16) return {1'b0, 3'b111, 1'b1, 2'b00, r};
    if (m < 20) return {1'b1, 3'b111, 1'b1, 2'b00, r};
    if (m < 28) return {1'b0, 3'b111, 1'b1, 2'b00, r};
    if (m < 36) return {1'b0, 3'b011, 1'b1, 2'b00, r};
    if (m < 44) return {1'b0, 3'b001, 1'b1, 2'b00, r};
    return {1'b0, 3'b000, 1'b1, 2'b00, r};
  endfunction
`endif

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
    link_live_i = 1'b1;
`else
    link_live_i = 1'b0;
`endif
    step();
    push(cyc, idle_v, "reset_state");
    check_cycle();
    reset_i = 1'b0;
    push(cyc + 1, idle_v, "idle_after_reset");
    step();

    // nominal run; a start pulse at k=10 must not disturb timing
    base = cyc;
    push(base, idle_v, "run1_k0");
    push_run(base, 1, 49, "run1");
    check_cycle();
    pulse_start();
    run_to(base + 10);
    pulse_start();
    run_to(base + 49);

    // restart from DONE
    base = cyc;
    push(base, done_v, "rerun_k0");
    push_run(base, 1, done_k + 1, "rerun");
    check_cycle();
    pulse_start();
    run_to(base + done_k + 1);

    // abort mid-sequence
    base = cyc;
    push(base, done_v, "abort_k0");
    push_run(base, 1, 30, "abort_run");
    for (int unsigned k = 31; k <= 33; k++) push(base + k, idle_v, "abort_idle");
    check_cycle();
    pulse_start();
    run_to(base + 30);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    run_to(base + 33);

    // abort and start together stay in IDLE
    base = cyc;
    for (int unsigned k = 1; k <= 3; k++) push(base + k, idle_v, "abort_beats_start");
    abort_i = 1'b1;
    start_i = 1'b1;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    run_to(base + 3);

    // synchronous reset while in TKN
    base = cyc;
    push(base, idle_v, "rst_k0");
    push_run(base, 1, 18, "rst_run");
    push(base + 19, idle_v, "rst_in_tkn");
    push(base + 20, idle_v, "rst_hold_idle");
    check_cycle();
    pulse_start();
    run_to(base + 18);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    run_to(base + 20);

    // nominal timing after mid-sequence reset
    base = cyc;
    push(base, idle_v, "post_rst_k0");
    push_run(base, 1, done_k + 2, "post_rst_run");
    check_cycle();
    pulse_start();
    run_to(base + done_k + 2);

`ifdef BSG_CHIP_LINK_BRINGUP_LIVE_CHECK_EN
    // no live: two retries then ERROR
    link_live_i = 1'b0;
    base = cyc;
    push(base, done_v, "retry_k0");
    for (int unsigned k = 1; k <= 162; k++) push(base + k, retry_vec(k), "retry_seq");
    check_cycle();
    pulse_start();
    run_to(base + 162);

    // recover from ERROR with live asserted
    link_live_i = 1'b1;
    base = cyc;
    push(base, err_v, "recover_k0");
    push_run(base, 1, done_k + 1, "recover_run");
    check_cycle();
    pulse_start();
    run_to(base + done_k + 1);

    // live only on the final WAIT_LIVE cycle
    link_live_i = 1'b0;
    base = cyc;
    push(base, done_v, "last_live_k0");
    for (int unsigned k = 1; k <= 53; k++) push(base + k, retry_vec(k), "last_live_wait");
    for (int unsigned k = 54; k <= 56; k++) push(base + k, done_v, "last_live_done");
    check_cycle();
    pulse_start();
    run_to(base + 53);
    link_live_i = 1'b1;
    step();
    run_to(base + 56);
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
